ray_sphere_axil_slave: RTL and testbench

AXI4-Lite responder fronting the ray–sphere intersection core; it is the peripheral end of the PS7 M_AXI_GP0 register traffic at base 0x43C00000. It holds ten 16-bit signed operands in five packed registers, launches the core via a valid/ready handshake on a write to CTRL, and reports status and the hit flag back to software. One outstanding read and one outstanding write at a time.

---
 rtl/ray_sphere_axil_slave.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_ray_sphere_axil_slave.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ray_sphere_axil_slave.sv
// AXI4-Lite register front end for the ray-sphere intersection core.
// Optional AXIL_WSTRB_EN: honour wstrb byte lanes on register and CTRL writes.
`timescale 1ns/1ps
module ray_sphere_axil_slave #(
    parameter int unsigned C_ADDR_WIDTH = 5,
    parameter int unsigned C_DATA_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic [C_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [C_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [C_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [C_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic                      core_valid,
    input  logic                      core_ready,
    input  logic                      core_done,
    input  logic                      core_hit,
    output logic [15:0]               op_sx,
    output logic [15:0]               op_sy,
    output logic [15:0]               op_sz,
    output logic [15:0]               op_r,
    output logic [15:0]               op_px,
    output logic [15:0]               op_py,
    output logic [15:0]               op_pz,
    output logic [15:0]               op_dx,
    output logic [15:0]               op_dy,
    output logic [15:0]               op_dz
);

    localparam int unsigned DW   = C_DATA_WIDTH;
    localparam int unsigned NB   = DW / 8;
    localparam int unsigned NREG = 5;
    localparam int unsigned IDXW = 3;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [IDXW-1:0] IDX_HIT  = 3'd5;
    localparam logic [IDXW-1:0] IDX_CTRL = 3'd6;

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;
    typedef enum logic [1:0] {C_IDLE, C_LAUNCH, C_BUSY} c_state_e;

    w_state_e        w_state_q, w_state_d;
    r_state_e        r_state_q, r_state_d;
    c_state_e        core_state_q, core_state_d;
    logic            awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
    logic            aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [IDXW-1:0] awidx_q, awidx_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [NB-1:0]   wstrb_q, wstrb_d;
    logic            bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]      bresp_q, bresp_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            core_valid_q, core_valid_d, hit_q, hit_d;
    logic [DW-1:0]   regs_q [NREG];
    logic [DW-1:0]   regs_d [NREG];

    logic            aw_fire, w_fire, ar_fire, core_idle, launch_c, wr_launch;
    logic [IDXW-1:0] wr_idx, rd_idx;
    logic [DW-1:0]   wr_data, wr_mask, rd_word;
    logic [NB-1:0]   wr_strb;
    logic            unused_bits;

    assign core_idle = (core_state_q == C_IDLE);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state_q    <= W_IDLE;
            r_state_q    <= R_IDLE;
            core_state_q <= C_IDLE;
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            arready_q    <= 1'b0;
            aw_held_q    <= 1'b0;
            w_held_q     <= 1'b0;
            awidx_q      <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            bvalid_q     <= 1'b0;
            bresp_q      <= RESP_OKAY;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            core_valid_q <= 1'b0;
            hit_q        <= 1'b0;
            for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            w_state_q    <= w_state_d;
            r_state_q    <= r_state_d;
            core_state_q <= core_state_d;
            awready_q    <= awready_d;
            wready_q     <= wready_d;
            arready_q    <= arready_d;
            aw_held_q    <= aw_held_d;
            w_held_q     <= w_held_d;
            awidx_q      <= awidx_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            bvalid_q     <= bvalid_d;
            bresp_q      <= bresp_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            core_valid_q <= core_valid_d;
            hit_q        <= hit_d;
            for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
        end
    end

    // Write channel: AW and W are held independently, the write commits once both are present.
    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awidx_d   = awidx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        launch_c  = 1'b0;
        for (int unsigned i = 0; i < NREG; i++) regs_d[i] = regs_q[i];

        aw_fire = s_axi_awvalid & awready_q;
        w_fire  = s_axi_wvalid & wready_q;
        wr_idx  = aw_held_q ? awidx_q : s_axi_awaddr[4:2];
        wr_data = w_held_q ? wdata_q : s_axi_wdata;
        wr_strb = w_held_q ? wstrb_q : s_axi_wstrb;
`ifdef AXIL_WSTRB_EN
        for (int unsigned b = 0; b < NB; b++) wr_mask[8*b +: 8] = {8{wr_strb[b]}};
        wr_launch = (wr_data[1:0] != 2'b00) && wr_strb[0];
`else
        wr_mask   = '1;
        wr_launch = (wr_data[1:0] != 2'b00);
`endif

        unique case (w_state_q)
            W_IDLE: begin
                if ((aw_held_q || aw_fire) && (w_held_q || w_fire)) begin
                    w_state_d = W_RESP;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    bresp_d   = RESP_OKAY;
                    if (wr_idx <= IDXW'(NREG - 1)) begin
                        if (!core_idle) begin
                            bresp_d = RESP_SLVERR;
                        end else begin
                            for (int unsigned i = 0; i < NREG; i++) begin
                                if (wr_idx == IDXW'(i))
                                    regs_d[i] = (regs_q[i] & ~wr_mask) | (wr_data & wr_mask);
                            end
                        end
                    end else if (wr_idx == IDX_CTRL && wr_launch) begin
                        if (!core_idle) bresp_d = RESP_SLVERR;
                        else            launch_c = 1'b1;
                    end
                end else begin
                    if (aw_fire) begin
                        aw_held_d = 1'b1;
                        awidx_d   = s_axi_awaddr[4:2];
                    end
                    if (w_fire) begin
                        w_held_d = 1'b1;
                        wdata_d  = s_axi_wdata;
                        wstrb_d  = s_axi_wstrb;
                    end
                    awready_d = !(aw_held_q || aw_fire);
                    wready_d  = !(w_held_q || w_fire);
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Core handshake sequencer; HIT is cleared on launch and loaded on done.
    always_comb begin
        core_state_d = core_state_q;
        hit_d        = hit_q;
        unique case (core_state_q)
            C_IDLE: begin
                if (launch_c) begin
                    core_state_d = C_LAUNCH;
                    hit_d        = 1'b0;
                end
            end
            C_LAUNCH: if (core_ready) core_state_d = C_BUSY;
            C_BUSY: begin
                if (core_done) begin
                    core_state_d = C_IDLE;
                    hit_d        = core_hit;
                end
            end
            default: core_state_d = C_IDLE;
        endcase
        core_valid_d = (core_state_d == C_LAUNCH);
    end

    // Read mux sees pre-edge state so a coincident status change is not visible.
    always_comb begin
        rd_idx  = s_axi_araddr[4:2];
        rd_word = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (rd_idx == IDXW'(i)) rd_word = regs_q[i];
        end
        if (rd_idx == IDX_HIT)  rd_word = DW'(hit_q);
        if (rd_idx == IDX_CTRL) rd_word = DW'(core_idle);
    end

    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        ar_fire   = s_axi_arvalid & arready_q;
        unique case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_fire) begin
                    r_state_d = R_DATA;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_word;
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    r_state_d = R_IDLE;
                    arready_d = 1'b1;
                    rvalid_d  = 1'b0;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

`ifdef AXIL_WSTRB_EN
    assign unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};
`else
    assign unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], wr_strb};
`endif

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = RESP_OKAY;
    assign core_valid    = core_valid_q;

    assign op_sx = regs_q[0][31:16];
    assign op_sy = regs_q[0][15:0];
    assign op_sz = regs_q[1][31:16];
    assign op_r  = regs_q[1][15:0];
    assign op_px = regs_q[2][31:16];
    assign op_py = regs_q[2][15:0];
    assign op_pz = regs_q[3][31:16];
    assign op_dx = regs_q[3][15:0];
    assign op_dy = regs_q[4][31:16];
    assign op_dz = regs_q[4][15:0];

endmodule

// File: tb/tb_ray_sphere_axil_slave.sv
// Randomized bench for ray_sphere_axil_slave against a register-map level reference model.
`timescale 1ns/1ps
module tb_ray_sphere_axil_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  s_axi_awaddr = '0, s_axi_araddr = '0;
    logic        s_axi_awvalid = 0, s_axi_wvalid = 0, s_axi_bready = 0, s_axi_arvalid = 0, s_axi_rready = 0;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic [31:0] s_axi_rdata;
    logic        core_valid, core_ready = 0, core_done = 0, core_hit = 0;
    logic [15:0] op_sx, op_sy, op_sz, op_r, op_px, op_py, op_pz, op_dx, op_dy, op_dz;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model: register file, hit flag, core phase (0 idle, 1 launch, 2 busy)
    logic [31:0] m_regs [5];
    logic        m_hit;
    int          m_core;

    always #5 clk = ~clk;

    ray_sphere_axil_slave dut (
        .ACLK(clk), .ARESETn(rst_n),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .core_valid(core_valid), .core_ready(core_ready), .core_done(core_done), .core_hit(core_hit),
        .op_sx(op_sx), .op_sy(op_sy), .op_sz(op_sz), .op_r(op_r), .op_px(op_px),
        .op_py(op_py), .op_pz(op_pz), .op_dx(op_dx), .op_dy(op_dy), .op_dz(op_dz)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) m_regs[i] = '0;
        m_hit  = 1'b0;
        m_core = 0;
    endtask

    function automatic logic [1:0] model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        int          idx = int'(a[4:2]);
        logic [31:0] lanes = '1;
        bit          launch = (d[1:0] != 2'b00);
`ifdef AXIL_WSTRB_EN
        for (int b = 0; b < 4; b++) if (!s[b]) lanes[8*b +: 8] = 8'h00;
        launch = launch && s[0];
`endif
        if (idx <= 4) begin
            if (m_core != 0) return 2'b10;
            m_regs[idx] = (m_regs[idx] & ~lanes) | (d & lanes);
            return 2'b00;
        end
        if (idx == 6 && launch) begin
            if (m_core != 0) return 2'b10;
            m_core = 1;
            m_hit  = 1'b0;
        end
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        int idx = int'(a[4:2]);
        if (idx <= 4) return m_regs[idx];
        if (idx == 5) return {31'b0, m_hit};
        if (idx == 6) return {31'b0, m_core == 0};
        return 32'h0;
    endfunction

    task automatic axi_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
        bit aw_pend = 1, w_pend = 1, af, wf, held = 1;
        int c = 0;
        resp = 2'bxx;
        @(posedge clk); #1;
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s; s_axi_bready = 0;
        while ((aw_pend || w_pend) && c < 64) begin
            if (aw_pend && c >= aw_dly) s_axi_awvalid = 1;
            if (w_pend && c >= w_dly)   s_axi_wvalid = 1;
            af = s_axi_awvalid && s_axi_awready;
            wf = s_axi_wvalid && s_axi_wready;
            @(posedge clk); #1;
            if (af) begin s_axi_awvalid = 0; aw_pend = 0; end
            if (wf) begin s_axi_wvalid = 0; w_pend = 0; end
            c++;
        end
        if (aw_pend || w_pend) begin
            chk("wr_handshake_timeout", 32'd0, 32'd1);
            s_axi_awvalid = 0; s_axi_wvalid = 0;
            return;
        end
        chk("b_latency", 32'(s_axi_bvalid), 32'd1);
        c = 0;
        while (!s_axi_bvalid && c < 64) begin @(posedge clk); #1; c++; end
        repeat (b_dly) begin
            @(posedge clk); #1;
            if (!s_axi_bvalid) held = 0;
        end
        if (b_dly > 0) chk("bvalid_held", 32'(held), 32'd1);
        resp = s_axi_bresp;
        s_axi_bready = 1;
        @(posedge clk); #1;
        s_axi_bready = 0;
    endtask

    task automatic axi_rd(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit af = 0;
        int c = 0;
        d = 'x; resp = 'x;
        @(posedge clk); #1;
        s_axi_araddr = a; s_axi_arvalid = 1; s_axi_rready = 0;
        while (!af && c < 64) begin
            af = s_axi_arready;
            @(posedge clk); #1;
            c++;
        end
        s_axi_arvalid = 0;
        chk("r_latency", 32'(s_axi_rvalid), 32'd1);
        if (!s_axi_rvalid) return;
        d = s_axi_rdata; resp = s_axi_rresp;
        s_axi_rready = 1;
        @(posedge clk); #1;
        s_axi_rready = 0;
    endtask

    task automatic do_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int ad, input int wd, input int bd, input string tag);
        logic [1:0] r, e;
        axi_wr(a, d, s, ad, wd, bd, r);
        e = model_write(a, d, s);
        chk($sformatf("%s@%h bresp", tag, a), 32'(r), 32'(e));
    endtask

    task automatic do_rd(input logic [4:0] a, input string tag);
        logic [31:0] d;
        logic [1:0]  r;
        axi_rd(a, d, r);
        chk($sformatf("%s@%h rdata", tag, a), d, model_read(a));
        chk($sformatf("%s@%h rresp", tag, a), 32'(r), 32'd0);
    endtask

    task automatic core_accept(input int dly);
        int c = 0;
        while (!core_valid && c < 32) begin @(posedge clk); #1; c++; end
        chk("core_valid_up", 32'(core_valid), 32'd1);
        repeat (dly) begin @(posedge clk); #1; end
        core_ready = 1;
        @(posedge clk); #1;
        core_ready = 0;
        m_core = 2;
        chk("core_valid_drop", 32'(core_valid), 32'd0);
    endtask

    task automatic core_finish(input logic hit, input int dly);
        repeat (dly) begin @(posedge clk); #1; end
        core_done = 1; core_hit = hit;
        @(posedge clk); #1;
        core_done = 0; core_hit = 0;
        m_core = 0;
        m_hit  = hit;
    endtask

    task automatic rand_op();
        logic [4:0] a = 5'($urandom);
        if ($urandom_range(0, 9) < 6)
            do_wr(a, $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                  $urandom_range(0, 2), "rnd_wr");
        else
            do_rd(a, "rnd_rd");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          c;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk); #1;
        chk("rst_awready", 32'(s_axi_awready), 0);
        chk("rst_wready", 32'(s_axi_wready), 0);
        chk("rst_arready", 32'(s_axi_arready), 0);
        chk("rst_bvalid", 32'(s_axi_bvalid), 0);
        chk("rst_rvalid", 32'(s_axi_rvalid), 0);
        chk("rst_core_valid", 32'(core_valid), 0);
        chk("rst_rdata", s_axi_rdata, 0);
        rst_n = 1;
        repeat (2) @(posedge clk); #1;
        chk("post_rst_awready", 32'(s_axi_awready), 1);
        chk("post_rst_wready", 32'(s_axi_wready), 1);
        chk("post_rst_arready", 32'(s_axi_arready), 1);
        for (int i = 0; i < 8; i++) do_rd(5'(4 * i), "rst_map");

        // Operand load and a full job with hit
        do_wr(5'h00, 32'h0000_0000, 4'hF, 0, 0, 0, "ld");
        do_wr(5'h04, 32'h0000_0002, 4'hF, 0, 0, 0, "ld");
        do_wr(5'h08, 32'h0000_000A, 4'hF, 0, 0, 0, "ld");
        do_wr(5'h0C, 32'h0000_0000, 4'hF, 0, 0, 0, "ld");
        do_wr(5'h10, 32'hFFFF_0000, 4'hF, 0, 0, 0, "ld");
        chk("op_r", 32'(op_r), 32'd2);
        chk("op_py", 32'(op_py), 32'd10);
        chk("op_dy", 32'(op_dy), 32'h0000_FFFF);
        do_wr(5'h18, 32'h1, 4'hF, 0, 0, 0, "launch");
        chk("launch_core_valid", 32'(core_valid), 1);
        do_rd(5'h18, "status_launch");
        core_accept(2);
        do_wr(5'h00, 32'h00A0_FFF6, 4'hF, 0, 0, 0, "busy_wr");
        do_wr(5'h18, 32'h2, 4'hF, 0, 0, 0, "busy_launch");
        chk("busy_op_sx", 32'(op_sx), 0);
        chk("busy_op_sy", 32'(op_sy), 0);
        chk("busy_no_relaunch", 32'(core_valid), 0);
        core_finish(1'b1, 3);
        do_rd(5'h18, "status_done");
        do_rd(5'h14, "hit_done");

        // Stray done while idle must not disturb HIT
        core_done = 1; core_hit = 0;
        @(posedge clk); #1;
        core_done = 0;
        do_rd(5'h14, "stray_done");

        // Read of STATUS on the same edge the job completes returns the pre-edge value
        do_wr(5'h18, 32'h3, 4'hF, 0, 0, 0, "launch2");
        core_accept(0);
        s_axi_araddr = 5'h18; s_axi_arvalid = 1; s_axi_rready = 0;
        core_done = 1; core_hit = 0;
        @(posedge clk); #1;
        core_done = 0; s_axi_arvalid = 0;
        m_core = 0; m_hit = 0;
        chk("coincident_rvalid", 32'(s_axi_rvalid), 1);
        chk("coincident_rdata", s_axi_rdata, 32'h0);
        s_axi_rready = 1;
        @(posedge clk); #1;
        s_axi_rready = 0;
        do_rd(5'h18, "status_after");
        do_rd(5'h14, "hit_after");

        // Channel ordering and back-pressure
        do_wr(5'h08, 32'h1234_5678, 4'hF, 3, 0, 0, "w_first");
        do_rd(5'h08, "w_first");
        do_wr(5'h0C, 32'h9ABC_DEF0, 4'hF, 0, 0, 4, "b_stall");
        do_rd(5'h0C, "b_stall");
        do_wr(5'h10, 32'h0BAD_F00D, 4'hF, 0, 2, 0, "aw_first");
        do_rd(5'h10, "aw_first");

        // Byte strobes
        do_wr(5'h04, 32'h00A0_0002, 4'hF, 0, 0, 0, "strb");
        do_wr(5'h04, 32'hFFFF_FFFF, 4'b0001, 0, 0, 0, "strb");
        axi_rd(5'h04, d, r);
`ifdef AXIL_WSTRB_EN
        chk("strb_lane0", d, 32'h00A0_00FF);
`else
        chk("strb_lane0", d, 32'hFFFF_FFFF);
`endif

        // Randomized traffic with interleaved jobs
        for (int it = 0; it < 150; it++) begin
            rand_op();
            if (m_core != 0) begin
                repeat ($urandom_range(0, 2)) rand_op();
                core_accept($urandom_range(0, 3));
                repeat ($urandom_range(0, 2)) rand_op();
                core_finish(1'($urandom), $urandom_range(0, 3));
            end
        end
        for (int i = 0; i < 8; i++) do_rd(5'(4 * i), "rnd_final");

        // Reset while launching with a read response pending
        do_wr(5'h00, 32'h1234_5678, 4'hF, 0, 0, 0, "pre_rst");
        do_wr(5'h18, 32'h1, 4'hF, 0, 0, 0, "pre_rst_launch");
        chk("pre_rst_core_valid", 32'(core_valid), 1);
        s_axi_araddr = 5'h14; s_axi_arvalid = 1; s_axi_rready = 0;
        c = 0;
        while (!s_axi_arready && c < 16) begin @(posedge clk); #1; c++; end
        @(posedge clk); #1;
        s_axi_arvalid = 0;
        chk("pre_rst_rvalid", 32'(s_axi_rvalid), 1);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_core_valid", 32'(core_valid), 0);
        chk("mid_rst_rvalid", 32'(s_axi_rvalid), 0);
        chk("mid_rst_awready", 32'(s_axi_awready), 0);
        chk("mid_rst_op_sx", 32'(op_sx), 0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1;
        model_reset();
        repeat (2) @(posedge clk); #1;
        for (int i = 0; i < 8; i++) do_rd(5'(4 * i), "post_rst");
        chk("post_rst_op_py", 32'(op_py), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
